// File: rtl/acc_bank_datapath.sv
// acc_bank_datapath
//   Bank of N_ACC accumulators fed from data memory, the sign-extended immediate
//   or the ALU result, plus the ALU B-operand mux and registered Zero/Neg flags.
//
// Ports
//   i_clock          system clock, rising edge
//   i_reset          asynchronous active-low reset
//   i_Clear          synchronous clear of all accumulators and flags
//   i_WrAcc          accumulator write enable
//   i_SelA           write source: 00 OutData, 01 ExtensionData, 10 ALU, 11 no-op
//   i_WrIdx          accumulator written
//   i_RdIdx          accumulator driven on o_ACC
//   i_SelB           B operand: 0 OutData, 1 ExtensionData
//   i_OutData        data-memory read value
//   i_ExtensionData  sign-extended immediate
//   i_ALU            ALU result
//   o_ACC            selected accumulator (ALU A operand)
//   o_SelB           ALU B operand
//   o_Zero           last written accumulator value == 0
//   o_Neg            last written accumulator value MSB
module acc_bank_datapath #(
  parameter int unsigned NBITS_D = 16,
  parameter int unsigned N_ACC   = 4,
  parameter int unsigned NBITS_I = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned REG_B   = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_Clear,
  input  logic               i_WrAcc,
  input  logic [1:0]         i_SelA,
  input  logic [NBITS_I-1:0] i_WrIdx,
  input  logic [NBITS_I-1:0] i_RdIdx,
  input  logic               i_SelB,
  input  logic [NBITS_D-1:0] i_OutData,
  input  logic [NBITS_D-1:0] i_ExtensionData,
  input  logic [NBITS_D-1:0] i_ALU,
  output logic [NBITS_D-1:0] o_ACC,
  output logic [NBITS_D-1:0] o_SelB,
  output logic               o_Zero,
  output logic               o_Neg
);

  logic [NBITS_D-1:0] r_acc [N_ACC];
  logic               r_zero;
  logic               r_neg;

  logic [NBITS_D-1:0] w_src;
  logic               w_wr_en;
  logic [NBITS_D-1:0] w_acc_rd;
  logic [NBITS_D-1:0] w_selb;

  // Write source mux; 11 is the no-op encoding.
  always_comb begin
    w_src = '0;
    case (i_SelA)
      2'b00:   w_src = i_OutData;
      2'b01:   w_src = i_ExtensionData;
      2'b10:   w_src = i_ALU;
      default: w_src = '0;
    endcase
  end

  // Out-of-range write indices are dropped rather than aliased onto a real slot.
  assign w_wr_en = i_WrAcc && (i_SelA != 2'b11) && (32'(i_WrIdx) < N_ACC);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < int'(N_ACC); k++) r_acc[k] <= '0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
    end else if (i_Clear) begin
      for (int k = 0; k < int'(N_ACC); k++) r_acc[k] <= '0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
    end else if (w_wr_en) begin
      for (int k = 0; k < int'(N_ACC); k++) begin
        if (i_WrIdx == NBITS_I'(k)) r_acc[k] <= w_src;
      end
      r_zero <= (w_src == '0);
      r_neg  <= w_src[NBITS_D-1];
    end
  end

  // Read port; indices past the bank return zero.
  always_comb begin
    w_acc_rd = '0;
    for (int k = 0; k < int'(N_ACC); k++) begin
      if (i_RdIdx == NBITS_I'(k)) w_acc_rd = r_acc[k];
    end
  end

  // Forwarding lets the ALU consume a value in the cycle it is produced.
  always_comb begin
    o_ACC = w_acc_rd;
    if (BYPASS != 0) begin
      if (i_Clear) begin
        o_ACC = '0;
      end else if (w_wr_en && (i_WrIdx == i_RdIdx)) begin
        o_ACC = w_src;
      end
    end
  end

  assign w_selb = i_SelB ? i_ExtensionData : i_OutData;

  generate
    if (REG_B != 0) begin : g_selb_reg
      logic [NBITS_D-1:0] r_selb;
      // Free-running capture; i_Clear intentionally leaves it alone.
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_selb <= '0;
        else          r_selb <= w_selb;
      end
      assign o_SelB = r_selb;
    end else begin : g_selb_comb
      assign o_SelB = w_selb;
    end
  endgenerate

  assign o_Zero = r_zero;
  assign o_Neg  = r_neg;

endmodule
